// File: rtl/memory_cycle.sv
// Memory-access stage of the RV32I pipeline: word load/store against an internal
// data memory, fault detection, and the M/W pipeline register with writeback mux.
module memory_cycle #(
  parameter int MEM_DEPTH = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  output logic        RegWriteW,
  output logic [4:0]  RD_W,
  output logic [31:0] ResultW,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic [31:0] PCPlus4W,
  output logic        MemFaultW
);

  logic [31:0] mem [MEM_DEPTH] = '{default: '0};

  logic [ADDR_W-1:0] idx;
  logic              misaligned;
  logic              out_of_range;
  logic              fault;
  logic              store_en;
  logic [31:0]       rdata;

  logic        reg_write_q, reg_write_d;
  logic [4:0]  rd_q,        rd_d;
  logic        res_src_q,   res_src_d;
  logic [31:0] alu_res_q,   alu_res_d;
  logic [31:0] rdata_q,     rdata_d;
  logic [31:0] pc4_q,       pc4_d;
  logic        fault_q,     fault_d;

  // M stage: address decode, fault detection and combinational read
  always_comb begin
    idx          = ALU_ResultM[ADDR_W+1:2];
    misaligned   = |ALU_ResultM[1:0];
    out_of_range = |ALU_ResultM[31:ADDR_W+2];
    fault        = (MemWriteM | ResultSrcM) & (misaligned | out_of_range);
    store_en     = MemWriteM & ~fault;
    rdata        = fault ? 32'h0 : mem[idx];
  end

  // Write lands at the edge, so a same-cycle load sees the old word.
  always_ff @(posedge clk) begin
    if (rst && store_en)
      mem[idx] <= WriteDataM;
  end

  always_comb begin
    reg_write_d = RegWriteM & ~(ResultSrcM & fault);
    rd_d        = RD_M;
    res_src_d   = ResultSrcM;
    alu_res_d   = ALU_ResultM;
    rdata_d     = rdata;
    pc4_d       = PCPlus4M;
    fault_d     = fault;
  end

  // M/W boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      res_src_q   <= 1'b0;
      alu_res_q   <= '0;
      rdata_q     <= '0;
      pc4_q       <= '0;
      fault_q     <= 1'b0;
    end else begin
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      res_src_q   <= res_src_d;
      alu_res_q   <= alu_res_d;
      rdata_q     <= rdata_d;
      pc4_q       <= pc4_d;
      fault_q     <= fault_d;
    end
  end

  // W stage: unregistered mux, execute forwards from it in the same cycle
  assign ResultW     = res_src_q ? rdata_q : alu_res_q;
  assign RegWriteW   = reg_write_q;
  assign RD_W        = rd_q;
  assign ALU_ResultW = alu_res_q;
  assign ReadDataW   = rdata_q;
  assign PCPlus4W    = pc4_q;
  assign MemFaultW   = fault_q;

endmodule

// File: tb/tb_memory_cycle.sv
// Directed bench for memory_cycle: stores, loads, faults, passthrough and reset.
module tb_memory_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic        RegWriteW;
  logic [4:0]  RD_W;
  logic [31:0] ResultW, ALU_ResultW, ReadDataW, PCPlus4W;
  logic        MemFaultW;

  int n_assert = 0;
  int n_fail   = 0;

  memory_cycle #(.MEM_DEPTH(1024), .ADDR_W(10)) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
    .ALU_ResultM(ALU_ResultM),
    .RegWriteW(RegWriteW), .RD_W(RD_W), .ResultW(ResultW),
    .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .MemFaultW(MemFaultW)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic rs, input logic rw, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] wd, input logic [31:0] addr);
    MemWriteM   = we;
    ResultSrcM  = rs;
    RegWriteM   = rw;
    RD_M        = rd;
    PCPlus4M    = pc;
    WriteDataM  = wd;
    ALU_ResultM = addr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 32'h0);
    tick();
    tick();
    check("rst_regwrite", {31'b0, RegWriteW}, 32'h0);
    check("rst_rd",       {27'b0, RD_W},      32'h0);
    check("rst_result",   ResultW,            32'h0);
    check("rst_alu",      ALU_ResultW,        32'h0);
    check("rst_rdata",    ReadDataW,          32'h0);
    check("rst_pc4",      PCPlus4W,           32'h0);
    check("rst_fault",    {31'b0, MemFaultW}, 32'h0);
    #2 rst = 1'b1;

    // Store then load
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h4, 32'hDEADBEEF, 32'h10);
    tick();
    check("st_nofault", {31'b0, MemFaultW}, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 5'd5, 32'h8, 32'h0, 32'h10);
    tick();
    check("ld_regwrite", {31'b0, RegWriteW}, 32'h1);
    check("ld_rd",       {27'b0, RD_W},      32'h5);
    check("ld_rdata",    ReadDataW,          32'hDEADBEEF);
    check("ld_result",   ResultW,            32'hDEADBEEF);

    // Read-during-write returns old data; next load sees the new word
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h11111111, 32'h10);
    tick();
    drive(1'b1, 1'b1, 1'b1, 5'd6, 32'h0, 32'h22222222, 32'h10);
    tick();
    check("rdw_old", ReadDataW, 32'h11111111);
    drive(1'b0, 1'b1, 1'b1, 5'd6, 32'h0, 32'h0, 32'h10);
    tick();
    check("rdw_new", ReadDataW, 32'h22222222);

    // Misaligned store and load
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'hAAAA5555, 32'h12);
    tick();
    check("mis_st_fault", {31'b0, MemFaultW}, 32'h1);
    drive(1'b0, 1'b1, 1'b1, 5'd9, 32'h0, 32'h0, 32'h13);
    tick();
    check("mis_ld_rdata", ReadDataW,          32'h0);
    check("mis_ld_rw",    {31'b0, RegWriteW}, 32'h0);
    check("mis_ld_fault", {31'b0, MemFaultW}, 32'h1);
    drive(1'b0, 1'b1, 1'b1, 5'd9, 32'h0, 32'h0, 32'h10);
    tick();
    check("mis_mem_kept", ReadDataW,          32'h22222222);
    check("mis_ok_fault", {31'b0, MemFaultW}, 32'h0);

    // Out of range: store suppressed, ALU op with same value is not a fault
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'h00000055, 32'h1000);
    tick();
    check("oor_st_fault", {31'b0, MemFaultW}, 32'h1);
    drive(1'b0, 1'b1, 1'b1, 5'd1, 32'h0, 32'h0, 32'h0);
    tick();
    check("oor_mem0_kept", ReadDataW, 32'h0);
    drive(1'b0, 1'b0, 1'b1, 5'd2, 32'h0, 32'h0, 32'h1000);
    tick();
    check("oor_alu_fault",  {31'b0, MemFaultW}, 32'h0);
    check("oor_alu_result", ResultW,            32'h1000);
    check("oor_alu_rw",     {31'b0, RegWriteW}, 32'h1);

    // ALU passthrough with one-cycle latency
    drive(1'b0, 1'b0, 1'b1, 5'd3, 32'h24, 32'h0, 32'h000000FF);
    #1;
    check("pt_before_edge", ResultW, 32'h1000);
    tick();
    check("pt_result", ResultW,  32'hFF);
    check("pt_pc4",    PCPlus4W, 32'h24);

    // Reset mid-store
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 32'hCAFEF00D, 32'h40);
    tick();
    drive(1'b0, 1'b1, 1'b1, 5'd7, 32'h100, 32'h0, 32'h40);
    tick();
    check("pre_rst_result", ResultW, 32'hCAFEF00D);
    drive(1'b1, 1'b1, 1'b1, 5'd7, 32'h104, 32'hBAD0BAD0, 32'h40);
    #2 rst = 1'b0;
    #1;
    check("mrst_regwrite", {31'b0, RegWriteW}, 32'h0);
    check("mrst_rd",       {27'b0, RD_W},      32'h0);
    check("mrst_result",   ResultW,            32'h0);
    check("mrst_alu",      ALU_ResultW,        32'h0);
    check("mrst_rdata",    ReadDataW,          32'h0);
    check("mrst_pc4",      PCPlus4W,           32'h0);
    tick();
    check("mrst_hold_pc4", PCPlus4W, 32'h0);
    #2 rst = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 5'd3, 32'h108, 32'h0, 32'h40);
    tick();
    check("post_rst_mem", ReadDataW,          32'hCAFEF00D);
    check("post_rst_rd",  {27'b0, RD_W},      32'h3);
    check("post_rst_rw",  {31'b0, RegWriteW}, 32'h1);
    drive(1'b0, 1'b1, 1'b1, 5'd4, 32'h10C, 32'h0, 32'h10);
    tick();
    check("post_rst_mem4", ResultW, 32'h22222222);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
